wave_lookup_interp: RTL

//  Parametrised phase-to-sample wavetable lookup for the voice path: turns a voice phase into an

---
 rtl/wave_lookup_interp.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/wave_lookup_interp.sv
// Wavetable lookup with direct / half-wave / quarter-wave symmetry and optional
// linear interpolation between adjacent table entries. It reads two entries from an
// external synchronous ROM and returns one registered sample per request.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are both
// high. The producer holds its payload stable while valid is high and ready is low.
// in_ready does not depend on in_valid. out_valid does not depend on out_ready.
module wave_lookup_interp #(
  parameter int PHASE_W  = 16,
  parameter int TABLE_AW = 6,
  parameter int FRAC_W   = 8,
  parameter int SAMPLE_W = 8,
  parameter int PROG_W   = 7,
  parameter int CH_W     = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PHASE_W-1:0]           phase,
  input  logic [PROG_W-1:0]            prog,
  input  logic [1:0]                   mode,
  input  logic                         interp_en,
  input  logic [CH_W-1:0]              in_ch,
  output logic                         rom_en,
  output logic [PROG_W+TABLE_AW-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0]          rom_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SAMPLE_W-1:0]          sample,
  output logic [CH_W-1:0]              out_ch,
  output logic [2:0]                   dbg_state
);

  localparam int PW = SAMPLE_W + FRAC_W + 2;
  localparam logic [TABLE_AW-1:0] IDX_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_CALC = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic                accept;
  logic [TABLE_AW-1:0] idx, nxt, a0_n, a1_n;
  logic [FRAC_W-1:0]   frac;
  logic                rev, inv, wrap;

  logic [TABLE_AW-1:0] a0_q, a1_q;
  logic [PROG_W-1:0]   prog_q;
  logic [FRAC_W-1:0]   frac_q;
  logic                inv_q;
  logic [CH_W-1:0]     ch_q;
  logic [SAMPLE_W-1:0] s0_q, sample_q;
  logic [CH_W-1:0]     out_ch_q;

  logic signed [SAMPLE_W:0] diff;
  logic signed [PW-1:0]     prod;
  logic [SAMPLE_W-1:0]      y;

  assign accept = in_valid & in_ready;

  // Split the phase into index/fraction and derive the symmetry flags for the mode.
  // Reversal maps i -> M-i, which for an all-ones M is a bitwise NOT of the index.
  always_comb begin
    idx  = phase[PHASE_W-1 -: TABLE_AW];
    frac = phase[PHASE_W-1-TABLE_AW -: FRAC_W];
    rev  = 1'b0;
    inv  = 1'b0;
    wrap = 1'b1;
    case (mode)
      2'b01: begin
        idx  = phase[PHASE_W-2 -: TABLE_AW];
        frac = phase[PHASE_W-2-TABLE_AW -: FRAC_W];
        rev  = phase[PHASE_W-1];
        inv  = phase[PHASE_W-1];
        wrap = 1'b0;
      end
      2'b10: begin
        idx  = phase[PHASE_W-3 -: TABLE_AW];
        frac = phase[PHASE_W-3-TABLE_AW -: FRAC_W];
        rev  = phase[PHASE_W-2];
        inv  = phase[PHASE_W-1];
        wrap = 1'b0;
      end
      default: ;
    endcase
    if (!interp_en) frac = '0;
    // Symmetric tables hold the last point instead of wrapping into the next segment.
    nxt  = (idx == IDX_MAX && !wrap) ? idx : idx + TABLE_AW'(1);
    a0_n = rev ? ~idx : idx;
    a1_n = rev ? ~nxt : nxt;
  end

  // Linear interpolation: y = s0 + floor((s1 - s0) * frac / 2^FRAC_W); s1 arrives on rom_data in CALC.
  always_comb begin
    diff = $signed({1'b0, rom_data}) - $signed({1'b0, s0_q});
    prod = PW'(diff) * PW'($signed({1'b0, frac_q}));
    y    = SAMPLE_W'(PW'($signed({1'b0, s0_q})) + (prod >>> FRAC_W));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and FSM-driven outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    rom_en    = 1'b0;
    rom_addr  = '0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) state_d = S_RD0;
      end
      S_RD0: begin
        rom_en   = 1'b1;
        rom_addr = {prog_q, a0_q};
        state_d  = S_RD1;
      end
      S_RD1: begin
        rom_en   = 1'b1;
        rom_addr = {prog_q, a1_q};
        state_d  = S_CALC;
      end
      S_CALC: state_d = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, first-sample capture and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_q     <= '0;
      a1_q     <= '0;
      prog_q   <= '0;
      frac_q   <= '0;
      inv_q    <= 1'b0;
      ch_q     <= '0;
      s0_q     <= '0;
      sample_q <= '0;
      out_ch_q <= '0;
    end else begin
      if (accept) begin
        a0_q   <= a0_n;
        a1_q   <= a1_n;
        prog_q <= prog;
        frac_q <= frac;
        inv_q  <= inv;
        ch_q   <= in_ch;
      end
      if (state_q == S_RD1) s0_q <= rom_data;
      if (state_q == S_CALC) begin
        sample_q <= inv_q ? ~y : y;
        out_ch_q <= ch_q;
      end
    end
  end

  assign sample    = sample_q;
  assign out_ch    = out_ch_q;
  assign dbg_state = state_q;

endmodule
